// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: funct3 codes, responder FSM states and the
// load-path lane select / extension used by both the core and the responder.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Pick the addressed lane(s) of a little-endian word and extend per funct3.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous read, per-byte write enables, no reset.
module dmem_array #(
  parameter int WORDS = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave: one request in flight, byte/half/word access
// with alignment checking, exactly one response per accepted request.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int WA    = ADDR_W - 2;
  localparam int WORDS = 2 ** WA;

  dmem_state_t       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;

  logic              accept, bad, arr_en;
  logic [3:0]        arr_we;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    bad = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default: ;
    endcase
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) bad = 1'b1;
    if (req_funct3[2] && req_wr)                            bad = 1'b1;
  end

  // Store data is replicated so each enabled lane already holds the right byte.
  always_comb begin
    arr_en    = accept && !bad;
    arr_we    = 4'b0000;
    arr_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        arr_wdata = {4{req_wdata[7:0]}};
        if (req_wr) arr_we = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        arr_wdata = {2{req_wdata[15:0]}};
        if (req_wr) arr_we = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: if (req_wr) arr_we = 4'b1111;
    endcase
    if (!arr_en) arr_we = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: if (accept) begin
        off_d = req_addr[1:0];
        f3_d  = req_funct3;
        if (bad || req_wr) begin
          rdata_d = '0;
          err_d   = bad;
          state_d = RESP;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        rdata_d = lane_extend(arr_rdata, off_q, f3_q);
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  dmem_array #(.WORDS(WORDS), .AW(WA)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load or store request at a time over a valid/ready handshake, performs RISC-V byte/half/word access with sign or zero extension on a 512-byte word-organised array, and returns exactly one response per request. Sits between the processor's load/store datapath (byte address, width/sign code, store data) and the data RAM. It replaces the always-ready combinational memory with a latency-tolerant, back-pressurable slave.

## Interface
- DATA_W, 32, data width in bits; only 32 supported
- ADDR_W, 9, byte-address width; array holds 2**ADDR_W/4 = 128 words
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; no array side effect

## Operation
- States: IDLE, READ, RESP. req_ready = (state == IDLE); rsp_valid = (state == RESP).
- IDLE: on req_valid & req_ready, decode. Error if funct3 in {011,110,111}, or funct3[1:0]==01 and addr[0]!=0, or funct3[1:0]==10 and addr[1:0]!=0; any funct3[2]=1 with req_wr=1 is also an error.
  - Error: rsp_err<=1, rsp_rdata<=0, go RESP.
  - Store: write array word addr[ADDR_W-1:2] with byte enables (B: 1 lane at addr[1:0]; H: lanes addr[1]*2..+1; W: all 4), data replicated into lanes; rsp_rdata<=0, rsp_err<=0, go RESP.
  - Load: issue synchronous array read, latch addr[1:0] and funct3, go READ.
- READ: array data valid; select lane, sign-extend (000/001) or zero-extend (100/101), register into rsp_rdata, rsp_err<=0, go RESP.
- RESP: hold rsp_rdata/rsp_err stable while rsp_ready=0; on rsp_ready go IDLE.
- Little-endian lane order. req_* ignored outside IDLE.
- Reset: state<=IDLE, rsp_rdata<=0, rsp_err<=0; array contents are NOT cleared. Reset mid-READ or mid-RESP drops the pending response; a store already written stays written.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 in the cycle after reset is sampled.
- Store/error: accept at edge N, rsp_valid high from N+1.
- Load: accept at edge N, READ during N..N+1, rsp_valid high from N+2.
- Response handshake at edge M: rsp_valid low and req_ready high from M+1; no overlap of request accept and pending response; peak throughput is 1 store per 2 cycles, 1 load per 3.
- Load after store to the same word sees new data (the store is committed before its response).
- rsp_rdata/rsp_err change only on transition into RESP or on reset.

## Structure
- Package riscv_mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum dmem_state_t {IDLE, READ, RESP}, and the lane-extract/extend function shared with the core's load path.
- Sub-module dmem_array: single-port 128x32 RAM, synchronous read, 4-bit byte-write enable, no reset.
- dmem_responder holds the FSM, decode/alignment check, and response register.

## Test plan
- SW 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after accept.
- After the previous case: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x010 -> 0xFFFFBEEF; LHU 0x012 -> 0x0000DEAD.
- SH 0x012 data 0x00001234, then LW 0x010 -> 0x1234BEEF; SB 0x010 data 0xAA, then LW 0x010 -> 0x1234BEAA.
- Misaligned LW 0x011, SH 0x013, funct3=011, and store with funct3=100 -> each returns rsp_err=1, rsp_rdata=0 one cycle after accept; LW 0x010 afterwards is unchanged.
- Load with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles, req_ready=0 throughout; IDLE one cycle after rsp_ready rises.
- Assert reset during READ of LW 0x010 -> next cycle rsp_valid=0, req_ready=1; the following LW 0x010 returns the pre-reset contents.
